// File: rtl/ecg_cls_pkg.sv
// Shared definitions for the ECG argmax classifier: activation width,
// default class count, index-width helper and the FSM state encoding.
package ecg_cls_pkg;

  localparam int ACT_W           = 8;
  localparam int DEF_NUM_CLASSES = 5;

  // Index width for n classes; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ecg_argmax_classifier_if.sv
// Frame-in / result-out handshake bundle for ecg_argmax_classifier.
// margin and low_conf exist only when ARGMAX_CONF_EN is defined.
interface ecg_argmax_classifier_if
  import ecg_cls_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
);
  localparam int IDX_W = idx_w(NUM_CLASSES);

  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_CLASSES*ACT_W-1:0] scores;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             class_idx;
  logic [ACT_W-1:0]             class_score;
  logic                         busy;
`ifdef ARGMAX_CONF_EN
  logic [ACT_W-1:0]             margin;
  logic                         low_conf;
`endif

  // Upstream controller / result consumer side.
  modport master (
    output in_valid, scores, out_ready,
    input  in_ready, out_valid, class_idx, class_score, busy
`ifdef ARGMAX_CONF_EN
    , input margin, low_conf
`endif
  );

  // Classifier side.
  modport slave (
    input  in_valid, scores, out_ready,
    output in_ready, out_valid, class_idx, class_score, busy
`ifdef ARGMAX_CONF_EN
    , output margin, low_conf
`endif
  );

endinterface

// File: rtl/argmax_cmp_step.sv
// One step of the sequential argmax: folds a single activation into the
// running best / index (and second-best when ARGMAX_CONF_EN is defined).
// Strictly greater-than, unsigned, so ties keep the lowest index.
module argmax_cmp_step
  import ecg_cls_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic              i_first,
  input  logic [ACT_W-1:0]  i_elem,
  input  logic [IDX_W-1:0]  i_elem_idx,
  input  logic [ACT_W-1:0]  i_best,
  input  logic [IDX_W-1:0]  i_best_idx,
`ifdef ARGMAX_CONF_EN
  input  logic [ACT_W-1:0]  i_second,
  output logic [ACT_W-1:0]  o_second,
`endif
  output logic [ACT_W-1:0]  o_best,
  output logic [IDX_W-1:0]  o_best_idx
);

  // Running best/second update for the current element.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_best     = i_best;
    o_best_idx = i_best_idx;
`ifdef ARGMAX_CONF_EN
    o_second   = i_second;
`endif
    if (i_first) begin
      o_best     = i_elem;
      o_best_idx = '0;
`ifdef ARGMAX_CONF_EN
      o_second   = '0;
`endif
    end else if (i_elem > i_best) begin
      o_best     = i_elem;
      o_best_idx = i_elem_idx;
`ifdef ARGMAX_CONF_EN
      o_second   = i_best;
    end else if (i_elem > i_second) begin
      o_second   = i_elem;
`endif
    end
  end

endmodule

// File: rtl/ecg_argmax_classifier.sv
// ECG argmax classifier: captures a frame of class activations, scans one
// class per cycle and holds the winning index/score until accepted.
// Optional confidence outputs (margin, low_conf) under ARGMAX_CONF_EN.
module ecg_argmax_classifier
  import ecg_cls_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
`ifdef ARGMAX_CONF_EN
  , parameter int MARGIN_TH = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  ecg_argmax_classifier_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_CLASSES);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACT_W-1:0]   r_bank [NUM_CLASSES];
  logic [IDX_W-1:0]   r_k;
  logic [ACT_W-1:0]   r_best;
  logic [IDX_W-1:0]   r_best_idx;
  logic [ACT_W-1:0]   w_best;
  logic [IDX_W-1:0]   w_best_idx;
  logic [IDX_W-1:0]   r_class_idx;
  logic [ACT_W-1:0]   r_class_score;
  logic               w_last;
  logic               w_accept;
`ifdef ARGMAX_CONF_EN
  logic [ACT_W-1:0]   r_second;
  logic [ACT_W-1:0]   w_second;
  logic [ACT_W-1:0]   w_margin;
  logic [ACT_W-1:0]   r_margin;
  logic               r_low_conf;
`endif

  assign w_last   = (r_k == IDX_W'(NUM_CLASSES - 1));
  assign w_accept = (r_state == IDLE) && bus.in_valid;

  argmax_cmp_step #(.IDX_W(IDX_W)) u_step (
    .i_first    (r_k == '0),
    .i_elem     (r_bank[r_k]),
    .i_elem_idx (r_k),
    .i_best     (r_best),
    .i_best_idx (r_best_idx),
`ifdef ARGMAX_CONF_EN
    .i_second   (r_second),
    .o_second   (w_second),
`endif
    .o_best     (w_best),
    .o_best_idx (w_best_idx)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: accept in IDLE, scan NUM_CLASSES cycles, hold until taken.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = SCAN;
      SCAN:    if (w_last)        w_state_nxt = HOLD;
      HOLD:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Score bank capture and scan counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the bank is a handful of flops, not a RAM, and clearing it guarantees an aborted frame leaves nothing behind.
      for (int i = 0; i < NUM_CLASSES; i++) r_bank[i] <= '0;
      r_k <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_bank[i] <= bus.scores[i*ACT_W +: ACT_W];
      r_k <= '0;
    end else if (r_state == SCAN && !w_last) begin
      r_k <= r_k + 1'b1;
    end
  end

  // Running best (and second-best) accumulators during SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_best     <= '0;
      r_best_idx <= '0;
`ifdef ARGMAX_CONF_EN
      r_second   <= '0;
`endif
    end else if (r_state == SCAN) begin
      r_best     <= w_best;
      r_best_idx <= w_best_idx;
`ifdef ARGMAX_CONF_EN
      r_second   <= w_second;
`endif
    end
  end

`ifdef ARGMAX_CONF_EN
  assign w_margin = w_best - w_second;
`endif

  // Result registers, loaded on the final scan step and held until the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_class_idx   <= '0;
      r_class_score <= '0;
`ifdef ARGMAX_CONF_EN
      r_margin      <= '0;
      r_low_conf    <= 1'b0;
`endif
    end else if (r_state == SCAN && w_last) begin
      r_class_idx   <= w_best_idx;
      r_class_score <= w_best;
`ifdef ARGMAX_CONF_EN
      r_margin      <= w_margin;
      r_low_conf    <= (w_margin < ACT_W'(MARGIN_TH));
`endif
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == HOLD);
  assign bus.busy        = (r_state != IDLE);
  assign bus.class_idx   = r_class_idx;
  assign bus.class_score = r_class_score;
`ifdef ARGMAX_CONF_EN
  assign bus.margin      = r_margin;
  assign bus.low_conf    = r_low_conf;
`endif

endmodule

// File: tb/tb_ecg_argmax_classifier.sv
// Directed testbench for ecg_argmax_classifier (NUM_CLASSES=5).
// margin/low_conf are checked only when ARGMAX_CONF_EN is defined.
module tb_ecg_argmax_classifier;
  import ecg_cls_pkg::*;

  localparam int NC = 5;
  localparam int IW = idx_w(NC);

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ecg_argmax_classifier_if #(.NUM_CLASSES(NC)) bus ();

  ecg_argmax_classifier #(.NUM_CLASSES(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*8-1:0] frame(input logic [7:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Wait for in_ready, present a frame for one edge, then count cycles to out_valid.
  task automatic drive_frame(input logic [NC*8-1:0] s, output int lat, output bit ok);
    int w;
    ok  = 1'b1;
    lat = -1;
    w   = 0;
    while (!bus.in_ready && w < 20) begin tick(); w++; end
    if (!bus.in_ready) begin ok = 1'b0; return; end
    bus.scores   = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    if (!bus.out_valid) ok = 1'b0;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.scores = '0;
    tick(); tick();
    reset = 1'b0;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
      n_err++;
    end
    n_vec++;
    if ({bus.class_idx, bus.class_score} !== {IW'(0), 8'd0}) begin
      $display("FAIL reset_result: got idx=%0d score=%0d expected 0/0", bus.class_idx, bus.class_score);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd0, 1'b0}) begin
      $display("FAIL reset_conf: got margin=%0d low=%b expected 0/0", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
  endtask

  task automatic test_basic();
    int lat; bit ok;
    drive_frame(frame(8'd10, 8'd40, 8'd127, 8'd3, 8'd0), lat, ok);
    n_vec++;
    if (!ok || lat !== 5) begin
      $display("FAIL basic_latency: got %0d cycles (ok=%b) expected 5", lat, ok);
      n_err++;
    end
    n_vec++;
    if ({bus.class_idx, bus.class_score} !== {IW'(2), 8'd127}) begin
      $display("FAIL basic_result: got idx=%0d score=%0d expected 2/127", bus.class_idx, bus.class_score);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd87, 1'b0}) begin
      $display("FAIL basic_conf: got margin=%0d low=%b expected 87/0", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    n_vec++;
    if ({bus.in_ready, bus.busy} !== 2'b01) begin
      $display("FAIL basic_hold_flags: got rdy/busy=%b expected 01", {bus.in_ready, bus.busy});
      n_err++;
    end
    release_result();
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      $display("FAIL basic_release: got vld/rdy/busy=%b expected 010", {bus.out_valid, bus.in_ready, bus.busy});
      n_err++;
    end
  endtask

  task automatic test_tie();
    int lat; bit ok;
    drive_frame(frame(8'd50, 8'd90, 8'd90, 8'd20, 8'd90), lat, ok);
    n_vec++;
    if (!ok || {bus.class_idx, bus.class_score} !== {IW'(1), 8'd90}) begin
      $display("FAIL tie_result: got idx=%0d score=%0d ok=%b expected 1/90", bus.class_idx, bus.class_score, ok);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd0, 1'b1}) begin
      $display("FAIL tie_conf: got margin=%0d low=%b expected 0/1", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    release_result();
  endtask

  task automatic test_zeros();
    int lat; bit ok;
    drive_frame(frame(8'd0, 8'd0, 8'd0, 8'd0, 8'd0), lat, ok);
    n_vec++;
    if (!ok || {bus.class_idx, bus.class_score} !== {IW'(0), 8'd0}) begin
      $display("FAIL zeros_result: got idx=%0d score=%0d ok=%b expected 0/0", bus.class_idx, bus.class_score, ok);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd0, 1'b1}) begin
      $display("FAIL zeros_conf: got margin=%0d low=%b expected 0/1", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    release_result();
  endtask

  task automatic test_unsigned();
    int lat; bit ok;
    drive_frame(frame(8'd200, 8'd127, 8'd0, 8'd0, 8'd0), lat, ok);
    n_vec++;
    if (!ok || {bus.class_idx, bus.class_score} !== {IW'(0), 8'd200}) begin
      $display("FAIL unsigned_result: got idx=%0d score=%0d ok=%b expected 0/200", bus.class_idx, bus.class_score, ok);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd73, 1'b0}) begin
      $display("FAIL unsigned_conf: got margin=%0d low=%b expected 73/0", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    release_result();
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    drive_frame(frame(8'd7, 8'd9, 8'd8, 8'd1, 8'd2), lat, ok);
    n_vec++;
    if (!ok || lat !== 5) begin
      $display("FAIL bp_latency: got %0d cycles (ok=%b) expected 5", lat, ok);
      n_err++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.scores   = frame(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
      tick();
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.busy, bus.class_idx, bus.class_score} !== {3'b101, IW'(1), 8'd9}) begin
        $display("FAIL bp_hold[%0d]: got vld/rdy/busy=%b idx=%0d score=%0d expected 101/1/9",
                 i, {bus.out_valid, bus.in_ready, bus.busy}, bus.class_idx, bus.class_score);
        n_err++;
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      $display("FAIL bp_release: got vld/rdy/busy=%b expected 010", {bus.out_valid, bus.in_ready, bus.busy});
      n_err++;
    end
    tick();
    n_vec++;
    if ({bus.in_ready, bus.busy} !== 2'b10) begin
      $display("FAIL bp_no_capture: got rdy/busy=%b expected 10", {bus.in_ready, bus.busy});
      n_err++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat; bit ok;
    bus.scores   = frame(8'd10, 8'd40, 8'd127, 8'd3, 8'd0);
    bus.in_valid = 1'b1;
    tick();                       // acceptance, k=0
    bus.in_valid = 1'b0;
    tick(); tick(); tick();       // k=3
    n_vec++;
    if ({bus.busy, bus.in_ready} !== 2'b10) begin
      $display("FAIL midscan_busy: got busy/rdy=%b expected 10", {bus.busy, bus.in_ready});
      n_err++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.class_idx, bus.class_score} !== {3'b100, IW'(0), 8'd0}) begin
      $display("FAIL midscan_reset: got rdy/vld/busy=%b idx=%0d score=%0d expected 100/0/0",
               {bus.in_ready, bus.out_valid, bus.busy}, bus.class_idx, bus.class_score);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd0, 1'b0}) begin
      $display("FAIL midscan_reset_conf: got margin=%0d low=%b expected 0/0", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    drive_frame(frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd5), lat, ok);
    n_vec++;
    if (!ok || lat !== 5 || {bus.class_idx, bus.class_score} !== {IW'(4), 8'd5}) begin
      $display("FAIL midscan_next: got idx=%0d score=%0d lat=%0d ok=%b expected 4/5/5",
               bus.class_idx, bus.class_score, lat, ok);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd1, 1'b1}) begin
      $display("FAIL midscan_next_conf: got margin=%0d low=%b expected 1/1", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    release_result();
  endtask

  task automatic test_back_to_back();
    int first_t, second_t, highs, w;
    first_t = -1; second_t = -1; highs = 0;
    bus.scores    = frame(8'd0, 8'd0, 8'd0, 8'd0, 8'd60);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus.out_valid) begin
        highs++;
        if (first_t < 0) first_t = t;
        else if (second_t < 0) second_t = t;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_vec++;
    if (highs !== 2 || first_t !== 6 || second_t !== 13) begin
      $display("FAIL b2b_timing: got %0d results at cycles %0d,%0d expected 2 at 6,13", highs, first_t, second_t);
      n_err++;
    end
    w = 0;
    while (!bus.out_valid && w < 20) begin tick(); w++; end
    n_vec++;
    if (!bus.out_valid || {bus.class_idx, bus.class_score} !== {IW'(4), 8'd60}) begin
      $display("FAIL b2b_result: got vld=%b idx=%0d score=%0d expected 1/4/60", bus.out_valid, bus.class_idx, bus.class_score);
      n_err++;
    end
`ifdef ARGMAX_CONF_EN
    n_vec++;
    if ({bus.margin, bus.low_conf} !== {8'd60, 1'b0}) begin
      $display("FAIL b2b_conf: got margin=%0d low=%b expected 60/0", bus.margin, bus.low_conf);
      n_err++;
    end
`endif
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_zeros();
    test_unsigned();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
